// File: rtl/hazard3_ahb_arbiter_n_pkg.sv
// hazard3_ahb_arbiter_n_pkg: shared AHB5 encodings and sizing helper for the N-port arbiter
package hazard3_ahb_arbiter_n_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE = 2'b00,
    HTRANS_NSEQ = 2'b10
  } htrans_e;
  localparam int HPROT_DATA = 0;
  localparam int HPROT_PRIV = 1;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hazard3_arb_priority_rr.sv
// hazard3_arb_priority_rr: one-hot grant to the first requester at or after ptr, wrapping
//   req : request vector
//   ptr : starting index (tie to 0 for fixed priority)
//   gnt : one-hot grant, or zero when nothing requests
module hazard3_arb_priority_rr
  import hazard3_ahb_arbiter_n_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [ptr_w(N)-1:0]  ptr,
  output logic [N-1:0]         gnt
);
  localparam int WP = ptr_w(N);
  logic          found;
  logic [WP-1:0] idx;
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = WP'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hazard3_ahb_arbiter_n.sv
// hazard3_ahb_arbiter_n: merges N load/store requesters onto one AHB5 master port
//   clk_always_on, rst_n             : clock, async active-low reset
//   src_* (in)                       : per-port address-phase request fields and write data
//   src_aph_ready / src_dph_*        : per-port address acceptance and data-phase responses
//   src_rdata                        : hrdata broadcast to all ports
//   h* (out) / hready,hresp,hexokay,hrdata (in) : AHB5 master port
module hazard3_ahb_arbiter_n
  import hazard3_ahb_arbiter_n_pkg::*;
#(
  parameter int                   N_PORTS      = 2,
  parameter int                   W_ADDR       = 32,
  parameter int                   W_DATA       = 32,
  parameter int                   RR_MODE      = 0,
  parameter logic [N_PORTS-1:0]   PIPE_MASK    = {N_PORTS{1'b1}},
  parameter logic [7:0]           HMASTER_BASE = 8'h00
) (
  input  logic                        clk_always_on,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          src_vld,
  input  logic [N_PORTS*W_ADDR-1:0]   src_addr,
  input  logic [N_PORTS-1:0]          src_write,
  input  logic [N_PORTS*3-1:0]        src_size,
  input  logic [N_PORTS-1:0]          src_priv,
  input  logic [N_PORTS-1:0]          src_excl,
  input  logic [N_PORTS*W_DATA-1:0]   src_wdata,
  output logic [N_PORTS-1:0]          src_aph_ready,
  output logic [N_PORTS-1:0]          src_dph_ready,
  output logic [N_PORTS-1:0]          src_dph_err,
  output logic [N_PORTS-1:0]          src_dph_exokay,
  output logic [W_DATA-1:0]           src_rdata,
  output logic [W_ADDR-1:0]           haddr,
  output logic                        hwrite,
  output logic [1:0]                  htrans,
  output logic [2:0]                  hsize,
  output logic [2:0]                  hburst,
  output logic [3:0]                  hprot,
  output logic                        hmastlock,
  output logic [7:0]                  hmaster,
  output logic                        hexcl,
  output logic [W_DATA-1:0]           hwdata,
  input  logic                        hready,
  input  logic                        hresp,
  input  logic                        hexokay,
  input  logic [W_DATA-1:0]           hrdata
);
  localparam int WP = ptr_w(N_PORTS);
  logic               hold_q, hold_d;
  logic [N_PORTS-1:0] gnt_prev_q, gnt_prev_d, dph_active_q, dph_active_d;
  logic [N_PORTS-1:0] elig, gnt_arb, gnt;
  logic [WP-1:0]      rr_ptr_q, rr_ptr_d, arb_ptr, g, dg;
  // A non-pipelined port must finish its data phase before it may be granted again
  assign elig    = src_vld & (PIPE_MASK | ~dph_active_q);
  assign arb_ptr = (RR_MODE != 0) ? rr_ptr_q : '0;
  hazard3_arb_priority_rr #(.N(N_PORTS)) u_arb (
    .req (elig),
    .ptr (arb_ptr),
    .gnt (gnt_arb)
  );
  always_comb begin
    gnt = hold_q ? gnt_prev_q : gnt_arb;
    g   = '0;
    dg  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      g  = gnt[i] ? WP'(i) : g;
      dg = dph_active_q[i] ? WP'(i) : dg;
    end
    htrans    = |gnt ? HTRANS_NSEQ : HTRANS_IDLE;
    haddr     = src_addr[int'(g)*W_ADDR +: W_ADDR];
    hwrite    = src_write[g];
    hsize     = src_size[int'(g)*3 +: 3];
    hexcl     = src_excl[g];
    hprot     = '0;
    hprot[HPROT_DATA] = 1'b1;
    hprot[HPROT_PRIV] = src_priv[g];
    hburst    = HBURST_SINGLE;
    hmastlock = 1'b0;
    hmaster   = HMASTER_BASE + 8'(g);
    hwdata    = src_wdata[int'(dg)*W_DATA +: W_DATA];
    // Hold through wait states; the first error cycle releases so the owner can withdraw
    hold_d       = htrans[1] && !hready && !hresp;
    gnt_prev_d   = gnt;
    dph_active_d = hready ? gnt : dph_active_q;
    rr_ptr_d     = (RR_MODE != 0 && hready && |gnt) ?
                   ((g == WP'(N_PORTS - 1)) ? '0 : g + WP'(1)) : rr_ptr_q;
  end
  assign src_aph_ready  = gnt & {N_PORTS{hready}};
  assign src_dph_ready  = dph_active_q & {N_PORTS{hready}};
  assign src_dph_err    = dph_active_q & {N_PORTS{hresp}};
  assign src_dph_exokay = dph_active_q & {N_PORTS{hexokay}};
  assign src_rdata      = hrdata;
  always_ff @(posedge clk_always_on or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= 1'b0;
      gnt_prev_q   <= '0;
      dph_active_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      hold_q       <= hold_d;
      gnt_prev_q   <= gnt_prev_d;
      dph_active_q <= dph_active_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_hazard3_ahb_arbiter_n.sv
// tb_hazard3_ahb_arbiter_n: directed checks of a fixed-priority and a round-robin 3-port arbiter
`define STEP @(posedge clk); #1;
module tb_hazard3_ahb_arbiter_n;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [2:0]  f_vld, r_vld;
  logic        f_hready, r_hready, f_hresp, r_hresp, hexokay;
  logic [95:0] src_addr, src_wdata;
  logic [2:0]  src_write, src_priv, src_excl;
  logic [8:0]  src_size;
  logic [31:0] hrdata;
  logic [2:0]  f_aph, f_dph, f_err, f_exok, r_aph, r_dph, r_err, r_exok;
  logic [31:0] f_rdata, r_rdata, f_haddr, r_haddr, f_hwdata, r_hwdata;
  logic        f_hwrite, r_hwrite, f_hmastlock, r_hmastlock, f_hexcl, r_hexcl;
  logic [1:0]  f_htrans, r_htrans;
  logic [2:0]  f_hsize, r_hsize, f_hburst, r_hburst;
  logic [3:0]  f_hprot, r_hprot;
  logic [7:0]  f_hmaster, r_hmaster;
  always #5 clk = ~clk;
  hazard3_ahb_arbiter_n #(.N_PORTS(3), .RR_MODE(0), .PIPE_MASK(3'b101), .HMASTER_BASE(8'h00)) u_f (
    .clk_always_on(clk), .rst_n(rst_n), .src_vld(f_vld), .src_addr(src_addr), .src_write(src_write),
    .src_size(src_size), .src_priv(src_priv), .src_excl(src_excl), .src_wdata(src_wdata),
    .src_aph_ready(f_aph), .src_dph_ready(f_dph), .src_dph_err(f_err), .src_dph_exokay(f_exok),
    .src_rdata(f_rdata), .haddr(f_haddr), .hwrite(f_hwrite), .htrans(f_htrans), .hsize(f_hsize),
    .hburst(f_hburst), .hprot(f_hprot), .hmastlock(f_hmastlock), .hmaster(f_hmaster), .hexcl(f_hexcl),
    .hwdata(f_hwdata), .hready(f_hready), .hresp(f_hresp), .hexokay(hexokay), .hrdata(hrdata));
  hazard3_ahb_arbiter_n #(.N_PORTS(3), .RR_MODE(1), .PIPE_MASK(3'b111), .HMASTER_BASE(8'h10)) u_r (
    .clk_always_on(clk), .rst_n(rst_n), .src_vld(r_vld), .src_addr(src_addr), .src_write(src_write),
    .src_size(src_size), .src_priv(src_priv), .src_excl(src_excl), .src_wdata(src_wdata),
    .src_aph_ready(r_aph), .src_dph_ready(r_dph), .src_dph_err(r_err), .src_dph_exokay(r_exok),
    .src_rdata(r_rdata), .haddr(r_haddr), .hwrite(r_hwrite), .htrans(r_htrans), .hsize(r_hsize),
    .hburst(r_hburst), .hprot(r_hprot), .hmastlock(r_hmastlock), .hmaster(r_hmaster), .hexcl(r_hexcl),
    .hwdata(r_hwdata), .hready(r_hready), .hresp(r_hresp), .hexokay(hexokay), .hrdata(hrdata));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (f_hburst !== 3'd0 || r_hburst !== 3'd0) begin
        errors++;
        $error("FAIL inv_hburst f=%0h r=%0h", f_hburst, r_hburst);
      end
      if (f_hmastlock !== 1'b0 || r_hmastlock !== 1'b0) begin
        errors++;
        $error("FAIL inv_hmastlock f=%0h r=%0h", f_hmastlock, r_hmastlock);
      end
      if (f_rdata !== hrdata || r_rdata !== hrdata) begin
        errors++;
        $error("FAIL inv_rdata f=%0h r=%0h", f_rdata, r_rdata);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; f_vld = '0; r_vld = '0; f_hready = 1'b1; r_hready = 1'b1;
    f_hresp = 1'b0; r_hresp = 1'b0; hexokay = 1'b0; hrdata = 32'h12345678;
    src_addr  = {32'h3000_0030, 32'h2000_0020, 32'h1000_0010};
    src_wdata = {32'hCCCC_0002, 32'hDEAD_BEEF, 32'hAAAA_0000};
    src_write = 3'b010; src_priv = 3'b010; src_excl = 3'b100;
    src_size  = {3'd0, 3'd1, 3'd2};
    `STEP #2;
    chk("rst_htrans", f_htrans, 2'b00);
    chk("rst_aph", f_aph, 3'b000);
    chk("rst_dph", f_dph, 3'b000);
    chk("rst_err", f_err, 3'b000);
    `STEP rst_n = 1'b1;
    `STEP f_vld = 3'b111; r_vld = 3'b111; #2;
    chk("fp_c1_aph", f_aph, 3'b001);
    chk("fp_c1_hmaster", f_hmaster, 8'h00);
    chk("fp_c1_haddr", f_haddr, 32'h1000_0010);
    chk("fp_c1_htrans", f_htrans, 2'b10);
    chk("fp_c1_hprot", f_hprot, 4'b0001);
    chk("fp_c1_hsize", f_hsize, 3'd2);
    chk("fp_c1_hburst", f_hburst, 3'd0);
    chk("fp_c1_hmastlock", f_hmastlock, 1'b0);
    chk("rr_c1_aph", r_aph, 3'b001);
    chk("rr_c1_hmaster", r_hmaster, 8'h10);
    `STEP hexokay = 1'b1; #2;
    chk("fp_c2_aph", f_aph, 3'b001);
    chk("fp_c2_dph", f_dph, 3'b001);
    chk("fp_c2_exok", f_exok, 3'b001);
    chk("rr_c2_aph", r_aph, 3'b010);
    chk("rr_c2_hmaster", r_hmaster, 8'h11);
    chk("rr_c2_haddr", r_haddr, 32'h2000_0020);
    chk("rr_c2_hprot", r_hprot, 4'b0011);
    chk("rr_c2_hwrite", r_hwrite, 1'b1);
    chk("rr_c2_dph", r_dph, 3'b001);
    chk("rr_c2_hwdata", r_hwdata, 32'hAAAA_0000);
    `STEP hexokay = 1'b0; #2;
    chk("fp_c3_aph", f_aph, 3'b001);
    chk("rr_c3_aph", r_aph, 3'b100);
    chk("rr_c3_hexcl", r_hexcl, 1'b1);
    chk("rr_c3_hsize", r_hsize, 3'd0);
    chk("rr_c3_hwdata", r_hwdata, 32'hDEAD_BEEF);
    `STEP #2;
    chk("rr_c4_wrap", r_aph, 3'b001);
    chk("rr_c4_dph", r_dph, 3'b100);
    chk("fp_c4_rdata", f_rdata, 32'h12345678);
    `STEP f_vld = '0; r_vld = '0; #2;
    chk("idle_f_htrans", f_htrans, 2'b00);
    chk("idle_r_htrans", r_htrans, 2'b00);
    chk("idle_f_dph", f_dph, 3'b001);
    `STEP
    `STEP f_vld = 3'b010; f_hready = 1'b0; #2;
    chk("hold_h0_aph", f_aph, 3'b000);
    chk("hold_h0_haddr", f_haddr, 32'h2000_0020);
    chk("hold_h0_hmaster", f_hmaster, 8'h01);
    `STEP f_vld = 3'b011; #2;
    chk("hold_h1_hmaster", f_hmaster, 8'h01);
    chk("hold_h1_haddr", f_haddr, 32'h2000_0020);
    `STEP #2;
    chk("hold_h2_aph", f_aph, 3'b000);
    `STEP f_hready = 1'b1; #2;
    chk("hold_h3_aph", f_aph, 3'b010);
    chk("hold_h3_hmaster", f_hmaster, 8'h01);
    `STEP #2;
    chk("hold_h4_aph", f_aph, 3'b001);
    chk("hold_h4_hmaster", f_hmaster, 8'h00);
    chk("hold_h4_dph", f_dph, 3'b010);
    `STEP f_vld = 3'b010; #2;
    chk("pipe_p0_aph", f_aph, 3'b010);
    chk("pipe_p0_hwrite", f_hwrite, 1'b1);
    `STEP #2;
    chk("pipe_p1_aph", f_aph, 3'b000);
    chk("pipe_p1_htrans", f_htrans, 2'b00);
    chk("pipe_p1_hwdata", f_hwdata, 32'hDEAD_BEEF);
    chk("pipe_p1_dph", f_dph, 3'b010);
    `STEP #2;
    chk("pipe_p2_aph", f_aph, 3'b010);
    `STEP f_vld = '0; #2;
    chk("pipe_p3_dph", f_dph, 3'b010);
    `STEP
    `STEP f_vld = 3'b001; #2;
    chk("err_e0_aph", f_aph, 3'b001);
    `STEP f_vld = 3'b010; f_hready = 1'b0; #2;
    chk("err_e1_htrans", f_htrans, 2'b10);
    chk("err_e1_err", f_err, 3'b000);
    chk("err_e1_dph", f_dph, 3'b000);
    `STEP f_hresp = 1'b1; #2;
    chk("err_e2_err", f_err, 3'b001);
    chk("err_e2_dph", f_dph, 3'b000);
    chk("err_e2_hmaster", f_hmaster, 8'h01);
    `STEP f_vld = '0; f_hready = 1'b1; #2;
    chk("err_e3_err", f_err, 3'b001);
    chk("err_e3_dph", f_dph, 3'b001);
    chk("err_e3_htrans", f_htrans, 2'b00);
    `STEP f_hresp = 1'b0;
    `STEP r_vld = 3'b100; #2;
    chk("rst2_r0_aph", r_aph, 3'b100);
    chk("rst2_r0_hmaster", r_hmaster, 8'h12);
    chk("rst2_r0_haddr", r_haddr, 32'h3000_0030);
    `STEP r_vld = '0; r_hready = 1'b0; #2;
    chk("rst2_r1_dph", r_dph, 3'b000);
    rst_n = 1'b0; #1;
    r_hready = 1'b1; r_hresp = 1'b1; #1;
    chk("rst2_dph", r_dph, 3'b000);
    chk("rst2_err", r_err, 3'b000);
    chk("rst2_htrans", r_htrans, 2'b00);
    `STEP rst_n = 1'b1; r_hresp = 1'b0; r_vld = 3'b111; #2;
    chk("rst2_a_aph", r_aph, 3'b001);
    chk("rst2_a_dph", r_dph, 3'b000);
    `STEP #2;
    chk("rst2_b_aph", r_aph, 3'b010);
    chk("rst2_b_dph", r_dph, 3'b001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
